// File: rtl/relu_pkg.sv
// Shared definitions for the ReLU output streamer: FSM states, the bias token
// value and the channel-index width helper.
package relu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD,
    DONE
  } state_t;

  localparam int BIAS_TOKEN = 1;

  // Width of an index that counts 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/relu_requant.sv
// Combinational requantiser: arithmetic right shift, ReLU, then saturation to
// the largest positive OUT_W-bit value. The result is zero-extended to OUT_W.
module relu_requant #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic [DATA_W-1:0] i_x,
  output logic [OUT_W-1:0]  o_y
);

  localparam logic signed [DATA_W-1:0] MAX_POS =
    {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  logic signed [DATA_W-1:0] w_x;

  assign w_x = $signed(i_x) >>> SHIFT;

  // NOTE: o_y gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    o_y = '0;
    if (w_x > MAX_POS) begin
      o_y = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_x > 0) begin
      o_y = w_x[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/relu_stream.sv
// Captures a vector of FC1 results and streams the ReLU-requantised channels
// over a valid/ready port. Define RELU_STREAM_BIAS_PAD_EN to append a bias token.
module relu_stream
  import relu_pkg::*;
#(
  parameter int N_CH   = 32,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_CH*DATA_W-1:0] in_vec,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_last,
  output logic                   done
);

  localparam int IW = idx_w(N_CH);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);
  localparam logic [IW-1:0] PENULT_IDX = IW'(N_CH - 2);

  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_done;
  logic [DATA_W-1:0] r_ch [N_CH];

  logic [DATA_W-1:0] w_ch;
  logic [OUT_W-1:0]  w_req;
  logic              w_hs;

  assign w_hs = r_out_valid & out_ready;

  // NOTE: the captured channels are never read before a start loads them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start && !rst) begin
      for (int k = 0; k < N_CH; k++) begin
        r_ch[k] <= in_vec[k*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= STREAM;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
`ifdef RELU_STREAM_BIAS_PAD_EN
            r_out_last  <= 1'b0;
`else
            r_out_last  <= (N_CH == 1);
`endif
          end
        end

        STREAM: begin
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
`ifdef RELU_STREAM_BIAS_PAD_EN
              r_state    <= PAD;
              r_out_last <= 1'b1;
`else
              r_state     <= DONE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
`ifdef RELU_STREAM_BIAS_PAD_EN
              r_out_last <= 1'b0;
`else
              r_out_last <= (r_idx == PENULT_IDX);
`endif
            end
          end
        end

`ifdef RELU_STREAM_BIAS_PAD_EN
        PAD: begin
          if (w_hs) begin
            r_state     <= DONE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif

        DONE: begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state     <= IDLE;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign w_ch = r_ch[r_idx];

  relu_requant #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_requant (
    .i_x (w_ch),
    .o_y (w_req)
  );

  // The word is a function of registered state only; it reads zero whenever nothing is offered.
  always_comb begin
    out_data = '0;
    if (r_out_valid) begin
      out_data = (r_state == PAD) ? OUT_W'(BIAS_TOKEN) : w_req;
    end
  end

  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule
